// File: rtl/mem_stage.sv
// EX/MEM latch plus data-memory req/ack controller: a non-memory op or zero-wait access takes 1 cycle, an N-cycle access takes N.
// While a request is pending the stage stalls upstream, holds its latch and sends bubbles to MEM/WB; a request is forced to complete after TIMEOUT cycles.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [1:0]  WB_i,
  input  logic [1:0]  M_i,
  input  logic [4:0]  RDaddr_i,
  input  logic [31:0] ALUdata_i,
  input  logic [31:0] WriteData_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [1:0]  WB_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] ALUdata_o,
  output logic [31:0] DataMem_o,
  output logic        err_o
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        v_q, v_d;
  logic [1:0]  wb_q, wb_d;
  logic [1:0]  m_q, m_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] wd_q, wd_d;

  logic memop;
  logic timeout;
  logic done;

  assign memop   = v_q & (m_q[0] | m_q[1]);
  assign timeout = (state_q == REQ) & (cnt_q == 8'(TIMEOUT - 1));
  assign done    = ~memop | mem_ack_i | timeout;

  assign mem_req_o   = memop;
  assign mem_we_o    = m_q[0];
  assign mem_addr_o  = alu_q;
  assign mem_wdata_o = wd_q;

  assign stall_o   = memop & ~done;
  assign WB_o      = (v_q & done) ? wb_q : 2'b00;
  assign RDaddr_o  = rd_q;
  assign ALUdata_o = alu_q;
  // A timed-out read has no ack, so it naturally returns zero here.
  assign DataMem_o = (v_q & m_q[1] & mem_ack_i) ? mem_rdata_i : 32'd0;
  assign err_o     = err_q;

  always_comb begin
    v_d   = v_q;
    wb_d  = wb_q;
    m_d   = m_q;
    rd_d  = rd_q;
    alu_d = alu_q;
    wd_d  = wd_q;
    if (!stall_o) begin
      v_d   = valid_i & ~flush_i;
      wb_d  = WB_i;
      m_d   = M_i;
      rd_d  = RDaddr_i;
      alu_d = ALUdata_i;
      wd_d  = WriteData_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q | (timeout & ~mem_ack_i);
    case (state_q)
      IDLE: begin
        if (memop && !mem_ack_i) begin
          state_d = REQ;
          cnt_d   = 8'd1;
        end
      end
      REQ: begin
        if (done) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      v_q     <= 1'b0;
      wb_q    <= 2'b00;
      m_q     <= 2'b00;
      rd_q    <= 5'd0;
      alu_q   <= 32'd0;
      wd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      v_q     <= v_d;
      wb_q    <= wb_d;
      m_q     <= m_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench: the driver predicts every cycle of each instruction from its ack latency and queues it; a negedge monitor compares.
module tb_mem_stage;

  localparam int T = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, flush_i;
  logic [1:0]  WB_i, M_i;
  logic [4:0]  RDaddr_i;
  logic [31:0] ALUdata_i, WriteData_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic [1:0]  WB_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] ALUdata_o, DataMem_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  mem_stage #(.TIMEOUT(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
    .WB_i(WB_i), .M_i(M_i), .RDaddr_i(RDaddr_i), .ALUdata_i(ALUdata_i),
    .WriteData_i(WriteData_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .WB_o(WB_o), .RDaddr_o(RDaddr_o),
    .ALUdata_o(ALUdata_o), .DataMem_o(DataMem_o), .err_o(err_o)
  );

  // lat: cycle on which memory acks; lat > T means it never does.
  typedef struct {
    logic        valid, flush;
    logic [1:0]  wb, m;
    logic [4:0]  rd;
    logic [31:0] alu, wd, rdat;
    int          lat;
  } inst_t;

  typedef struct {
    logic        stall, req, we, err, chk;
    logic [1:0]  wb;
    logic [4:0]  rd;
    logic [31:0] addr, wdata, alu, dm;
  } exp_t;

  exp_t  q[$];
  int    vectors = 0;
  int    miscompares = 0;
  logic  err_m = 1'b0;
  bit    post_rst = 1'b0;
  inst_t zero_inst = '{1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 1};

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endfunction

  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall_o", 32'(stall_o), 32'(e.stall));
      chk("mem_req_o", 32'(mem_req_o), 32'(e.req));
      chk("WB_o", 32'(WB_o), 32'(e.wb));
      chk("err_o", 32'(err_o), 32'(e.err));
      if (e.req) begin
        chk("mem_we_o", 32'(mem_we_o), 32'(e.we));
        chk("mem_addr_o", mem_addr_o, e.addr);
        chk("mem_wdata_o", mem_wdata_o, e.wdata);
      end
      if (e.chk) begin
        chk("RDaddr_o", 32'(RDaddr_o), 32'(e.rd));
        chk("ALUdata_o", ALUdata_o, e.alu);
        chk("DataMem_o", DataMem_o, e.dm);
      end
    end
  end

  task automatic drive(input inst_t n);
    valid_i = n.valid; flush_i = n.flush; WB_i = n.wb; M_i = n.m;
    RDaddr_i = n.rd; ALUdata_i = n.alu; WriteData_i = n.wd;
  endtask

  // Upstream should hold during a stall; junk here proves the latch ignores it.
  task automatic drive_junk();
    valid_i = 1'($urandom); flush_i = 1'($urandom); WB_i = 2'($urandom); M_i = 2'($urandom);
    RDaddr_i = 5'($urandom); ALUdata_i = $urandom; WriteData_i = $urandom;
  endtask

  function automatic inst_t rand_inst();
    inst_t r;
    r.valid = ($urandom_range(0, 7) != 0);
    r.flush = ($urandom_range(0, 7) == 0);
    r.wb = 2'($urandom); r.m = 2'($urandom); r.rd = 5'($urandom);
    r.alu = $urandom; r.wd = $urandom; r.rdat = $urandom;
    r.lat = $urandom_range(1, T + 2);
    return r;
  endfunction

  // Called just after the edge that loaded c; returns just after c's completion edge.
  task automatic run_inst(input inst_t c, input inst_t n, input int rst_j);
    bit   v, memop;
    int   k;
    exp_t e;
    v = c.valid && !c.flush;
    memop = v && (c.m != 2'b00);
    k = memop ? ((c.lat < T) ? c.lat : T) : 1;
    for (int j = 1; j <= k; j++) begin
      if (j == k) drive(n); else drive_junk();
      rst_i = (j == rst_j);
      mem_ack_i = memop ? (j == c.lat) : 1'($urandom);
      mem_rdata_i = (memop && j == c.lat) ? c.rdat : $urandom;
      e.stall = memop && (j < k);
      e.req = memop;
      e.we = c.m[0]; e.addr = c.alu; e.wdata = c.wd;
      e.wb = (v && j == k) ? c.wb : 2'b00;
      e.chk = (v && j == k) || post_rst;
      e.rd = c.rd; e.alu = c.alu;
      e.dm = (memop && c.m[1] && j == c.lat) ? c.rdat : 32'd0;
      e.err = err_m;
      post_rst = 1'b0;
      q.push_back(e);
      if (memop && c.lat > T && j == T) err_m = 1'b1;
      @(posedge clk_i); #1;
      if (j == rst_j) begin
        rst_i = 1'b0; err_m = 1'b0; post_rst = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    inst_t list[$];
    inst_t cur, nxt, t;
    rst_i = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
    drive(zero_inst);

    t = zero_inst; t.valid = 1; t.wb = 2'b01; t.rd = 5'd5; t.alu = 32'h10;
    list.push_back(t);
    t = zero_inst; t.valid = 1; t.m = 2'b10; t.wb = 2'b11; t.rd = 5'd7; t.alu = 32'h40; t.rdat = 32'hCAFEF00D;
    list.push_back(t);
    t = zero_inst; t.valid = 1; t.m = 2'b01; t.wb = 2'b00; t.alu = 32'h80; t.wd = 32'h1234; t.lat = 3;
    list.push_back(t);
    t = zero_inst; t.valid = 1; t.m = 2'b10; t.wb = 2'b11; t.rd = 5'd9; t.alu = 32'h44; t.lat = T + 2;
    list.push_back(t);
    t = zero_inst; t.valid = 1; t.flush = 1; t.m = 2'b10; t.wb = 2'b11; t.alu = 32'h48;
    list.push_back(t);
    for (int i = 0; i < 150; i++) list.push_back(rand_inst());
    t = zero_inst; t.valid = 1; t.m = 2'b10; t.wb = 2'b11; t.rd = 5'd3; t.alu = 32'h4C; t.lat = T + 2;
    list.push_back(t);

    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0; post_rst = 1'b1;
    cur = zero_inst;
    foreach (list[i]) begin
      nxt = list[i];
      run_inst(cur, nxt, 0);
      cur = nxt;
    end
    run_inst(cur, zero_inst, 2);
    run_inst(zero_inst, zero_inst, 0);
    @(negedge clk_i);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
